// File: rtl/des_dec_keysched.sv
// DES decryption key schedule: emits K16..K1 one per beat over a valid/ready
// handshake, rotating the PC-1 halves right so they return to C0/D0 at the end.
module des_dec_keysched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:64] the_key,
  input  logic        ki_ready,
  output logic [1:48] ki,
  output logic        ki_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  state_t       state_reg, state_next;
  logic [1:28]  c_reg, d_reg;
  logic [1:28]  c_rot, d_rot;
  logic [1:48]  ki_reg;
  logic         ki_valid_reg;
  logic [3:0]   round_reg;
  logic [1:56]  pc1_key;
  logic [1:56]  pc2_src;
  logic [1:48]  pc2_out;
  logic         rot_one;
  logic         accept;
  logic         parity_unused;
  logic         cd_unused;

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_key[gi+1] = the_key[PC1_TAB[gi]];
    end
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign pc2_out[gi+1] = pc2_src[PC2_TAB[gi]];
    end
  endgenerate

  // Parity bits of the key and the eight CD bits PC-2 drops carry no information.
  assign parity_unused = ^{the_key[8], the_key[16], the_key[24], the_key[32],
                           the_key[40], the_key[48], the_key[56], the_key[64]};
  assign cd_unused = ^{pc2_src[9], pc2_src[18], pc2_src[22], pc2_src[25],
                       pc2_src[35], pc2_src[38], pc2_src[43], pc2_src[54]};

  // Single-bit right rotations lead into decrypt rounds 1, 8 and 15; the extra
  // one on the final beat brings the registers back to C0/D0 (total of 28).
  assign rot_one = (round_reg == 4'd0) || (round_reg == 4'd7) ||
                   (round_reg == 4'd14) || (round_reg == 4'd15);
  assign c_rot = rot_one ? {c_reg[28], c_reg[1:27]} : {c_reg[27:28], c_reg[1:26]};
  assign d_rot = rot_one ? {d_reg[28], d_reg[1:27]} : {d_reg[27:28], d_reg[1:26]};

  // First EMIT cycle registers PC-2 of the freshly loaded halves; later beats
  // register PC-2 of the rotated halves alongside the rotation itself.
  assign pc2_src = ki_valid_reg ? {c_rot, d_rot} : {c_reg, d_reg};
  assign accept  = (state_reg == EMIT) && ki_valid_reg && ki_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = EMIT;
      EMIT: if (accept && (round_reg == 4'd15)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      LOAD, EMIT: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // The key is folded through PC-1 on the accept edge, so later the_key changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg        <= '0;
      d_reg        <= '0;
      ki_reg       <= '0;
      ki_valid_reg <= 1'b0;
      round_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            c_reg     <= pc1_key[1:28];
            d_reg     <= pc1_key[29:56];
            round_reg <= 4'd0;
          end
        end
        EMIT: begin
          if (!ki_valid_reg) begin
            ki_reg       <= pc2_out;
            ki_valid_reg <= 1'b1;
          end else if (ki_ready) begin
            c_reg <= c_rot;
            d_reg <= d_rot;
            if (round_reg == 4'd15) begin
              ki_valid_reg <= 1'b0;
            end else begin
              round_reg <= round_reg + 4'd1;
              ki_reg    <= pc2_out;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ki       = ki_reg;
  assign ki_valid = ki_valid_reg;
  assign round    = round_reg;

endmodule

// File: doc/des_dec_keysched.md
DES_DEC_KEYSCHED -- requirements
Module: des_dec_keysched

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a decrypt schedule; sampled only in IDLE.
REQ-005 the_key  input  [1:64]  DES key, bit 1 = MSB, parity bits 8,16,...,64 ignored; sampled on the accepted start cycle only.
REQ-006 ki_ready  input  1  consumer accepts current subkey when high with ki_valid.
REQ-007 ki  output  [1:48]  current round subkey, PC-2 ordering per FIPS 46-3.
REQ-008 ki_valid  output  1  ki holds a valid subkey.
REQ-009 round  output  [3:0]  decrypt round index 0..15; round n carries encrypt subkey K(16-n).
REQ-010 busy  output  1  high from the cycle after start is accepted until the last subkey is accepted.
REQ-011 done  output  1  one-cycle pulse the cycle after round 15 is accepted.

Function
REQ-012 FSM states: IDLE, LOAD, EMIT, DONE; reset state IDLE.
REQ-013 IDLE->LOAD on start=1; start in any other state SHALL be ignored.
REQ-014 LOAD: C,D registers <= PC-1(the_key); next state EMIT with round=0; no rotation applied (C16=C0, D16=D0).
REQ-015 EMIT: ki = PC-2(C,D) registered; ki_valid=1; ki and round SHALL stay stable while ki_ready=0.
REQ-016 Beat accepted when ki_valid & ki_ready; on acceptance with round<15, round increments and C,D rotate RIGHT by r(round+1).
REQ-017 Right-rotate amounts r(1..15) for decrypt rounds 1..15: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (28-bit circular, C and D independently).
REQ-018 Acceptance with round=15 -> DONE; ki_valid drops next cycle; no further rotation.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; start in DONE ignored.
REQ-020 Latency: start accepted at edge t -> ki_valid=1, round=0 after edge t+2; with ki_ready tied high, 16 consecutive valid beats, done after the 16th.
REQ-021 ki SHALL be registered (no combinational path from the_key or ki_ready to ki).
REQ-022 After the full schedule, C,D SHALL equal C0,D0 (cumulative right rotation 28); bench checks this via internal probe.
REQ-023 A new key SHALL be accepted only from IDLE; the_key changes during LOAD/EMIT SHALL NOT affect output.

Reset
REQ-024 rst=1 at any edge, including mid-schedule with ki_valid high: state<=IDLE, ki<=0, ki_valid<=0, round<=0, busy<=0, done<=0, C,D<=0.
REQ-025 rst has priority over start; start asserted with rst SHALL be dropped.
REQ-026 First start after reset deassertion SHALL behave identically to power-up.

Verification
REQ-027 Key 133457799BBCDFF1, start pulse, ki_ready=1 -> round 0 ki=CB3D8B0E17F5, round 15 ki=1B02EFFC7072, done one cycle after round 15.
REQ-028 Same key, compare all 16 beats against reference encrypt schedule reversed (K16..K1) -> exact match every round.
REQ-029 Backpressure: ki_ready toggles random, held low 5 cycles at round 7 -> ki/round frozen, sequence unchanged, 16 beats total.
REQ-030 Start re-asserted and the_key changed while busy -> ignored; outputs match first key's schedule.
REQ-031 rst pulsed at round 9 -> next cycle all outputs 0, IDLE; subsequent start with same key yields full correct 16-beat schedule.
REQ-032 Parity-bit flips only (key 123457799BBCDFF0 style, bits 8..64 altered) -> identical subkeys to unflipped key.
